// File: rtl/ram_rd_burst.sv
// ram_rd_burst: burst read engine for a 1R1W RAM with a credit-checked output FIFO.
// Build option: define RAM_RD_BURST_STAT_EN to add the stall_cnt output (saturating stall counter).
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   cmd_valid/cmd_ready           burst command handshake (cmd_addr start, cmd_len word count, 0 = no-op)
//   ram_re/ram_raddr/ram_rdata    RAM read port, rdata valid RD_LAT cycles after re
//   dout_valid/dout_ready         output word stream (dout_data, dout_last on final word)
//   stall_cnt                     cycles with dout_valid && !dout_ready (option only)
module ram_rd_burst #(
    parameter int NWORDS = 1024,
    parameter int WORDSZ = 32,
    parameter int ADDRSZ = 10,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [ADDRSZ-1:0] cmd_addr,
    input  logic [ADDRSZ:0]   cmd_len,
    output logic              ram_re,
    output logic [ADDRSZ-1:0] ram_raddr,
    input  logic [WORDSZ-1:0] ram_rdata,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic [WORDSZ-1:0] dout_data,
    output logic              dout_last
`ifdef RAM_RD_BURST_STAT_EN
    ,
    output logic [31:0]       stall_cnt
`endif
);
    localparam int BUF_DEPTH = RD_LAT + 1;
    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = 4;
    localparam logic [ADDRSZ:0] ONE = 1;

    typedef enum logic {IDLE, BURST} state_t;

    state_t            state_q, state_d;
    logic [ADDRSZ-1:0] addr_q, addr_d;
    logic [ADDRSZ:0]   rem_q, rem_d;
    logic [RD_LAT-1:0] pv_q, pv_d, pl_q, pl_d;
    logic [WORDSZ:0]   buf_q [BUF_DEPTH];
    logic [PW-1:0]     wp_q, wp_d, rp_q, rp_d;
    logic [CW-1:0]     cnt_q, cnt_d, inflight;
    logic              push, pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RD_LAT; i++) inflight = inflight + CW'(pv_q[i]);
    end

    assign pop        = dout_valid && dout_ready;
    assign push       = pv_q[RD_LAT-1];
    assign cmd_ready  = state_q == IDLE;
    assign ram_raddr  = addr_q;
    // Every issued read owns a buffer slot; a same-cycle pop frees one immediately.
    assign ram_re     = state_q == BURST && (inflight + cnt_q - CW'(pop)) < CW'(BUF_DEPTH);
    assign dout_valid = cnt_q != '0;
    assign {dout_last, dout_data} = buf_q[rp_q];

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        rem_d   = rem_q;
        if (state_q == IDLE && cmd_valid && cmd_len != '0) begin
            state_d = BURST;
            addr_d  = cmd_addr;
            rem_d   = cmd_len;
        end else if (ram_re) begin
            addr_d  = (addr_q == ADDRSZ'(NWORDS - 1)) ? '0 : addr_q + ADDRSZ'(1);
            rem_d   = rem_q - ONE;
            state_d = (rem_q == ONE) ? IDLE : BURST;
        end
        // Tag pipe tracks which returning RAM cycles carry real words.
        pv_d    = pv_q;
        pl_d    = pl_q;
        pv_d[0] = ram_re;
        pl_d[0] = ram_re && rem_q == ONE;
        for (int i = 1; i < RD_LAT; i++) begin
            pv_d[i] = pv_q[i-1];
            pl_d[i] = pl_q[i-1];
        end
        wp_d  = push ? nxt(wp_q) : wp_q;
        rp_d  = pop ? nxt(rp_q) : rp_q;
        cnt_d = cnt_q + CW'(push) - CW'(pop);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            addr_q  <= '0;
            rem_q   <= '0;
            pv_q    <= '0;
            pl_q    <= '0;
            wp_q    <= '0;
            rp_q    <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) buf_q[i] <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            rem_q   <= rem_d;
            pv_q    <= pv_d;
            pl_q    <= pl_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            cnt_q   <= cnt_d;
            if (push) buf_q[wp_q] <= {pl_q[RD_LAT-1], ram_rdata};
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (rst) !(push && !pop && cnt_q == CW'(BUF_DEPTH)));

`ifdef RAM_RD_BURST_STAT_EN
    logic [31:0] stall_q, stall_d;

    assign stall_d   = (dout_valid && !dout_ready && stall_q != '1) ? stall_q + 32'd1 : stall_q;
    assign stall_cnt = stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) stall_q <= '0;
        else     stall_q <= stall_d;
    end
`endif
endmodule
